// File: rtl/tx_pkg.sv
// Shared definitions for the transmit-path input logic.
//   debounce_state_t        : debouncer FSM states
//   DEBOUNCE_CYCLES_DEFAULT : stable samples needed to accept a level change
//                             (10 ms at 100 MHz)
package tx_pkg;

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } debounce_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/button_debouncer_stable_counter.sv
// stable_counter: counts consecutive stable samples for the debouncer.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   clr_i  : force count to zero (takes priority over inc_i)
//   inc_i  : increment count by one
//   tc_o   : count has reached MAX_COUNT-1 (terminal count)
// The FSM clears the count on acceptance and on every glitch, so the count
// never exceeds MAX_COUNT-1 and no wrap-around is possible.
module stable_counter #(
  parameter int unsigned MAX_COUNT = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(MAX_COUNT - 1));

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: debounces a synchronized button level and turns each
// accepted press into a held request with acknowledge handshake.
//   clk           : clock, all state updates on posedge
//   rst_n         : asynchronous active-low reset
//   din           : synchronized raw input level
//   db_level      : debounced level
//   rise_pulse    : one-cycle pulse on accepted 0->1
//   fall_pulse    : one-cycle pulse on accepted 1->0
//   press_req     : set by accepted press, cleared by press_ack
//   press_ack     : consumer acknowledge
//   press_overrun : sticky, a press arrived while press_req was still high
//   overrun_clr   : clears press_overrun (a coincident set wins)
// All outputs are registered.
module button_debouncer
  import tx_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic db_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic press_req,
  input  logic press_ack,
  output logic press_overrun,
  input  logic overrun_clr
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  debounce_state_t state_q, state_d;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic req_q, req_d;
  logic ovr_q, ovr_d;
  logic cnt_clr, cnt_inc, cnt_tc;

  stable_counter #(
    .MAX_COUNT(DEBOUNCE_CYCLES),
    .CNT_W    (CNT_W)
  ) u_stable_counter (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_o  (cnt_tc)
  );

  // The counter is always zero in the STABLE states, so "counter=1" on
  // entering a WAIT state is realised as a plain increment.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (din) begin
          state_d = WAIT_HI;
          cnt_inc = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      WAIT_HI: begin
        if (!din) begin
          state_d = STABLE_LO;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d = STABLE_HI;
          cnt_clr = 1'b1;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STABLE_HI: begin
        if (!din) begin
          state_d = WAIT_LO;
          cnt_inc = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      WAIT_LO: begin
        if (din) begin
          state_d = STABLE_HI;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d = STABLE_LO;
          cnt_clr = 1'b1;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // A new press coinciding with an ack replaces the acknowledged one.
  always_comb begin
    req_d = req_q;
    ovr_d = ovr_q;
    if (rise_d) begin
      req_d = 1'b1;
    end else if (press_ack) begin
      req_d = 1'b0;
    end
    if (rise_d && req_q && !press_ack) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE_LO;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      req_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      req_q   <= req_d;
      ovr_q   <= ovr_d;
    end
  end

  assign db_level      = level_q;
  assign rise_pulse    = rise_q;
  assign fall_pulse    = fall_q;
  assign press_req     = req_q;
  assign press_overrun = ovr_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with DEBOUNCE_CYCLES=4.
// Reference model: a level change is accepted when the last D samples
// since reset all differ from the current debounced level.
module tb_button_debouncer;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst_n, din, press_ack, overrun_clr;
  logic db_level, rise_pulse, fall_pulse, press_req, press_overrun;

  always #5 clk = ~clk;

  button_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .db_level     (db_level),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .press_req    (press_req),
    .press_ack    (press_ack),
    .press_overrun(press_overrun),
    .overrun_clr  (overrun_clr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  bit hist[$];
  bit m_level, m_rise, m_fall, m_req, m_ovr;
  int dut_rises;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    hist.delete();
    m_level = 0; m_rise = 0; m_fall = 0; m_req = 0; m_ovr = 0;
  endtask

  task automatic model_edge(input bit d, input bit a, input bit c);
    bit all_diff;
    bit ovr_set;
    hist.push_back(d);
    if (hist.size() > D) void'(hist.pop_front());
    m_rise = 0;
    m_fall = 0;
    if (hist.size() == D) begin
      all_diff = 1;
      foreach (hist[i]) if (hist[i] == m_level) all_diff = 0;
      if (all_diff) begin
        m_level = !m_level;
        if (m_level) m_rise = 1;
        else m_fall = 1;
      end
    end
    ovr_set = m_rise && m_req && !a;
    if (m_rise) m_req = 1;
    else if (a) m_req = 0;
    if (ovr_set) m_ovr = 1;
    else if (c) m_ovr = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".level"}, db_level, m_level);
    check({tag, ".rise"}, rise_pulse, m_rise);
    check({tag, ".fall"}, fall_pulse, m_fall);
    check({tag, ".req"}, press_req, m_req);
    check({tag, ".ovr"}, press_overrun, m_ovr);
    check({tag, ".excl"}, rise_pulse & fall_pulse, 1'b0);
  endtask

  task automatic step(input string tag, input bit d, input bit a, input bit c);
    din = d;
    press_ack = a;
    overrun_clr = c;
    @(posedge clk);
    #1;
    model_edge(d, a, c);
    if (rise_pulse === 1'b1) dut_rises++;
    check_outputs(tag);
  endtask

  task automatic hold(input string tag, input bit d, input int n);
    for (int i = 0; i < n; i++) step(tag, d, 1'b0, 1'b0);
  endtask

  initial begin
    bit cur;
    int len;
    rst_n = 0; din = 0; press_ack = 0; overrun_clr = 0;
    dut_rises = 0;
    model_reset();
    #12;
    check_outputs("reset");
    rst_n = 1;

    // Clean press: rise must appear on the 4th sample of din=1.
    hold("idle", 1'b0, 3);
    hold("clean_pre", 1'b1, 3);
    check("clean_no_early", rise_pulse, 1'b0);
    step("clean_acc", 1'b1, 1'b0, 1'b0);
    check("clean_rise", rise_pulse, 1'b1);
    check("clean_req", press_req, 1'b1);
    hold("clean_hold", 1'b1, 6);

    // Handshake, then an ack while idle.
    step("ack", 1'b1, 1'b1, 1'b0);
    check("ack_clears", press_req, 1'b0);
    step("ack_idle", 1'b1, 1'b1, 1'b0);
    hold("rel1", 1'b0, 6);

    // Bounce: 1,1,0 then a run of four 1s.
    dut_rises = 0;
    hold("bnc", 1'b1, 2);
    step("bnc0", 1'b0, 1'b0, 1'b0);
    hold("bnc_run", 1'b1, 3);
    check("bnc_no_early", db_level, 1'b0);
    step("bnc_acc", 1'b1, 1'b0, 1'b0);
    check("bnc_rise", rise_pulse, 1'b1);
    hold("bnc_hold", 1'b1, 4);
    check("bnc_one_rise", logic'(dut_rises == 1), 1'b1);

    // Release keeps req; second press without ack overruns.
    hold("rel2", 1'b0, 6);
    check("rel_req_kept", press_req, 1'b1);
    hold("ovr_press", 1'b1, 6);
    check("ovr_set", press_overrun, 1'b1);
    check("ovr_req", press_req, 1'b1);
    step("ovr_clr", 1'b1, 1'b0, 1'b1);
    check("ovr_cleared", press_overrun, 1'b0);

    // Ack coincident with a new rise: req stays, no overrun.
    hold("rel3", 1'b0, 6);
    hold("coin_pre", 1'b1, 3);
    step("coin", 1'b1, 1'b1, 1'b0);
    check("coin_req", press_req, 1'b1);
    check("coin_ovr", press_overrun, 1'b0);
    hold("rel4", 1'b0, 6);

    // Reset in the middle of WAIT_HI with din held high.
    hold("wait_hi", 1'b1, 2);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_outputs("async_rst");
    din = 1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1;
    hold("post_rst", 1'b1, 3);
    check("post_rst_no_early", db_level, 1'b0);
    step("post_rst_acc", 1'b1, 1'b0, 1'b0);
    check("post_rst_rise", rise_pulse, 1'b1);
    hold("post_rst_hold", 1'b1, 3);

    // Randomized bouncing input with random ack/clear activity.
    cur = 1'b1;
    for (int r = 0; r < 600; r++) begin
      if ($urandom_range(0, 1) == 1) cur = !cur;
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++)
        step("rand", cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
